// File: rtl/rr_coder_if.sv
// Request/result bundle for rr_coder: request vector with valid/ready in,
// encoded index plus one-hot grant and flags with valid/ready out.
interface rr_coder_if #(
  parameter int N = 8,
  parameter int W = $clog2(N)
);
  logic [N-1:0] I;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] Y;
  logic [N-1:0] OD;
  logic         zero;
  logic         multi;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output I, in_valid, out_ready,
    input  in_ready, Y, OD, zero, multi, out_valid
  );

  modport slave (
    input  I, in_valid, out_ready,
    output in_ready, Y, OD, zero, multi, out_valid
  );
endinterface

// File: rtl/rr_coder.sv
// N-to-log2(N) priority/round-robin encoder with registered one-hot grant,
// zero/multi-hot flags and a single-entry valid/ready output register.
module rr_coder #(
  parameter int N    = 8,
  parameter int W    = $clog2(N),
  parameter int MODE = 0
) (
  input  logic       clk,
  input  logic       rst,
  rr_coder_if.slave  bus
);

  logic [W-1:0]   ptr;
  logic [W-1:0]   win;
  logic [W-1:0]   win_fp;
  logic [W-1:0]   win_rr;
  logic [W-1:0]   off;
  logic [W:0]     sum;
  logic [W-1:0]   ptr_nxt;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   od_nxt;
  logic           found;
  logic           any_set;
  logic           many_set;
  logic           accept;

  logic [W-1:0]   y_p0;
  logic [N-1:0]   od_p0;
  logic           zero_p0;
  logic           multi_p0;
  logic           vld_p0;

  assign bus.in_ready  = !vld_p0 || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.Y         = y_p0;
  assign bus.OD        = od_p0;
  assign bus.zero      = zero_p0;
  assign bus.multi     = multi_p0;
  assign bus.out_valid = vld_p0;

  always_comb begin
    any_set  = 1'b0;
    many_set = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (bus.I[k]) begin
        many_set = many_set | any_set;
        any_set  = 1'b1;
      end
    end
  end

  // Fixed priority: the last set bit seen while scanning upward is the highest.
  always_comb begin
    win_fp = '0;
    for (int k = 0; k < N; k++) begin
      if (bus.I[k]) win_fp = W'(k);
    end
  end

  // Round-robin: rotate the request vector so ptr lands at bit 0, take the
  // lowest set bit, then map the offset back modulo N (not 2^W).
  always_comb begin
    dbl   = {bus.I, bus.I} >> ptr;
    off   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (dbl[k] && !found) begin
        off   = W'(k);
        found = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
    win_rr = sum[W-1:0];
  end

  always_comb begin
    win     = (MODE == 0) ? win_fp : win_rr;
    od_nxt  = any_set ? (N'(1) << win) : '0;
    ptr_nxt = (win == W'(N-1)) ? '0 : win + 1'b1;
  end

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      y_p0     <= '0;
      od_p0    <= '0;
      zero_p0  <= 1'b0;
      multi_p0 <= 1'b0;
      ptr      <= '0;
    end else begin
      if (accept) begin
        vld_p0   <= 1'b1;
        y_p0     <= any_set ? win : '0;
        od_p0    <= od_nxt;
        zero_p0  <= !any_set;
        multi_p0 <= many_set;
        if (MODE == 1 && any_set) ptr <= ptr_nxt;
      end else if (vld_p0 && bus.out_ready) begin
        vld_p0 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_coder.sv
// Bench for rr_coder: three instances (N=8 fixed, N=8 round-robin, N=5
// round-robin) driven by directed steps and random traffic against a model.
module tb_rr_coder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_coder_if #(.N(8))        b0 ();
  rr_coder_if #(.N(8))        b1 ();
  rr_coder_if #(.N(5), .W(3)) b2 ();

  rr_coder #(.N(8), .MODE(0))        u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  rr_coder #(.N(8), .MODE(1))        u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  rr_coder #(.N(5), .W(3), .MODE(1)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  int n_chk  = 0;
  int n_fail = 0;

  int nn   [3] = '{8, 8, 5};
  int mode [3] = '{0, 1, 1};
  int m_valid[3], m_y[3], m_od[3], m_zero[3], m_multi[3], m_ptr[3];

  logic [31:0] oy, ood, oz, om, oov, oir;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic int popc(input logic [31:0] v);
    int c = 0;
    for (int i = 0; i < 32; i++) if (v[i]) c++;
    return c;
  endfunction

  // Winner from the rules: highest set index, or first set bit from ptr upward with wrap.
  function automatic int pick(input int s, input logic [31:0] v);
    if (mode[s] == 0) begin
      for (int i = nn[s] - 1; i >= 0; i--) if (v[i]) return i;
    end else begin
      for (int k = 0; k < nn[s]; k++) if (v[(m_ptr[s] + k) % nn[s]]) return (m_ptr[s] + k) % nn[s];
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      m_valid[s] = 0; m_y[s] = 0; m_od[s] = 0;
      m_zero[s] = 0; m_multi[s] = 0; m_ptr[s] = 0;
    end
  endtask

  task automatic drive(input int s, input bit iv, input logic [31:0] v, input bit ordy);
    case (s)
      0: begin b0.in_valid = iv; b0.I = v[7:0]; b0.out_ready = ordy; end
      1: begin b1.in_valid = iv; b1.I = v[7:0]; b1.out_ready = ordy; end
      default: begin b2.in_valid = iv; b2.I = v[4:0]; b2.out_ready = ordy; end
    endcase
  endtask

  task automatic obs(input int s);
    case (s)
      0: begin oy = 32'(b0.Y); ood = 32'(b0.OD); oz = 32'(b0.zero); om = 32'(b0.multi);
               oov = 32'(b0.out_valid); oir = 32'(b0.in_ready); end
      1: begin oy = 32'(b1.Y); ood = 32'(b1.OD); oz = 32'(b1.zero); om = 32'(b1.multi);
               oov = 32'(b1.out_valid); oir = 32'(b1.in_ready); end
      default: begin oy = 32'(b2.Y); ood = 32'(b2.OD); oz = 32'(b2.zero); om = 32'(b2.multi);
               oov = 32'(b2.out_valid); oir = 32'(b2.in_ready); end
    endcase
  endtask

  // One clock of traffic on instance s; checks in_ready before the edge and all outputs after.
  task automatic cycle(input int s, input bit iv, input logic [31:0] v, input bit ordy);
    logic [31:0] vv;
    bit acc;
    vv = v & ((32'd1 << nn[s]) - 32'd1);
    drive(s, iv, vv, ordy);
    #1;
    obs(s);
    chk($sformatf("in_ready[%0d]", s), oir, (m_valid[s] == 0 || ordy) ? 32'd1 : 32'd0);
    acc = iv && (m_valid[s] == 0 || ordy);
    if (acc) begin
      if (vv == 0) begin
        m_y[s] = 0; m_od[s] = 0; m_zero[s] = 1; m_multi[s] = 0;
      end else begin
        m_y[s] = pick(s, vv);
        m_od[s] = 1 << m_y[s];
        m_zero[s] = 0;
        m_multi[s] = (popc(vv) >= 2) ? 1 : 0;
        if (mode[s] == 1) m_ptr[s] = (m_y[s] + 1) % nn[s];
      end
      m_valid[s] = 1;
    end else if (m_valid[s] != 0 && ordy) begin
      m_valid[s] = 0;
    end
    @(posedge clk);
    #1;
    obs(s);
    chk($sformatf("out_valid[%0d]", s), oov, 32'(m_valid[s]));
    chk($sformatf("Y[%0d]", s),         oy,  32'(m_y[s]));
    chk($sformatf("OD[%0d]", s),        ood, 32'(m_od[s]));
    chk($sformatf("zero[%0d]", s),      oz,  32'(m_zero[s]));
    chk($sformatf("multi[%0d]", s),     om,  32'(m_multi[s]));
    @(negedge clk);
  endtask

  task automatic check_cleared(input int s, input string tag);
    obs(s);
    chk({tag, "_valid"}, oov, 32'd0);
    chk({tag, "_Y"},     oy,  32'd0);
    chk({tag, "_OD"},    ood, 32'd0);
    chk({tag, "_zero"},  oz,  32'd0);
    chk({tag, "_multi"}, om,  32'd0);
    chk({tag, "_ready"}, oir, 32'd1);
  endtask

  int rr_exp [4] = '{0, 2, 7, 0};
  int n5_exp [3] = '{0, 4, 0};
  logic [31:0] rv;

  initial begin
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 32'd0, 1'b1);
    model_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) check_cleared(s, "reset");
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) check_cleared(s, "post_reset");

    for (int i = 0; i < 8; i++) begin
      cycle(0, 1'b1, 32'd1 << i, 1'b1);
      chk("sweep_Y", oy, 32'(i));
      chk("sweep_OD", ood, 32'd1 << i);
    end

    cycle(0, 1'b1, 32'h52, 1'b1);
    chk("fp_multi_Y", oy, 32'd6);
    chk("fp_multi_OD", ood, 32'h40);
    chk("fp_multi_flag", om, 32'd1);
    cycle(0, 1'b1, 32'h00, 1'b1);
    chk("fp_zero_flag", oz, 32'd1);
    chk("fp_zero_Y", oy, 32'd0);
    chk("fp_zero_OD", ood, 32'd0);
    chk("fp_zero_valid", oov, 32'd1);

    cycle(0, 1'b1, 32'h08, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1'b1, $urandom, 1'b0);
      chk("stall_Y", oy, 32'd3);
      chk("stall_OD", ood, 32'h08);
      chk("stall_ready", oir, 32'd0);
    end
    cycle(0, 1'b1, 32'h20, 1'b1);
    chk("release_Y", oy, 32'd5);
    chk("release_valid", oov, 32'd1);
    for (int j = 0; j < 10; j++) begin
      cycle(0, 1'b1, 32'd1 << (j % 8), 1'b1);
      chk("b2b_Y", oy, 32'(j % 8));
      chk("b2b_valid", oov, 32'd1);
    end

    for (int i = 0; i < 4; i++) begin
      cycle(1, 1'b1, 32'h85, 1'b1);
      chk("rr_Y", oy, 32'(rr_exp[i]));
    end
    cycle(1, 1'b1, 32'h00, 1'b1);
    chk("rr_zero_flag", oz, 32'd1);
    cycle(1, 1'b1, 32'h85, 1'b1);
    chk("rr_after_zero_Y", oy, 32'd2);

    for (int i = 0; i < 3; i++) begin
      cycle(2, 1'b1, 32'h11, 1'b1);
      chk("n5_Y", oy, 32'(n5_exp[i]));
    end

    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 300; i++) begin
        case ($urandom_range(0, 3))
          0: rv = 32'd0;
          1: rv = 32'd1 << $urandom_range(0, nn[s] - 1);
          default: rv = $urandom;
        endcase
        cycle(s, $urandom_range(0, 3) != 0, rv, $urandom_range(0, 3) != 0);
      end
    end

    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    cycle(1, 1'b1, 32'h04, 1'b1);
    chk("pre_rst_Y", oy, 32'd2);
    cycle(1, 1'b0, 32'h00, 1'b0);
    chk("pre_rst_valid", oov, 32'd1);
    rst = 1'b1;
    #1;
    check_cleared(1, "async_rst");
    #1;
    rst = 1'b0;
    model_reset();
    cycle(1, 1'b1, 32'hFF, 1'b1);
    chk("post_rst_Y", oy, 32'd0);
    chk("post_rst_OD", ood, 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_coder.md
# rr_coder

Parametrised N-to-log2(N) encoder with a registered one-hot decode, a valid/ready handshake on both sides and a selectable fixed-priority or round-robin resolution mode. It supersedes the 8-to-3 combinational encoder/decoder pair. It sits between request sources (interrupt lines, channel requests) and the index consumer, and presents both the encoded index and its one-hot grant. It flags multi-hot and all-zero input vectors instead of silently producing an ambiguous code.

## Interface
- N, default 8: number of request inputs; must be ≥ 2.
- W, default $clog2(N): index width; must be ≥ 1.
- MODE, default 0: 0 = fixed priority (highest index wins); 1 = round-robin.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- I  input  N  request vector; any number of bits may be set.
- in_valid  input  1  I is valid.
- in_ready  output  1  block accepts I this cycle.
- Y  output  W  encoded index of the winning bit.
- OD  output  N  one-hot decode of Y; all zero when zero = 1.
- zero  output  1  accepted vector was all zeros.
- multi  output  1  accepted vector had two or more bits set.
- out_valid  output  1  Y/OD/zero/multi hold a result.
- out_ready  input  1  consumer takes the result this cycle.

## Operation
- Single-entry output register. in_ready = !out_valid || out_ready (combinational from out_ready).
- Accept: in_valid && in_ready at a rising edge.
  - On accept, the result is computed from I and loaded into the output register.
  - out_valid is set to 1.
- Release: out_valid && out_ready without a simultaneous accept clears out_valid. Y, OD, zero and multi keep their last values.
- MODE 0: Y = highest set index of I.
- MODE 1: the search starts at pointer ptr and runs upward, wrapping from N-1 to 0. The first set bit wins.
- ptr (W bits, internal):
  - Updates only on an accept with I ≠ 0 in MODE 1.
  - New value: ptr = (Y_new + 1) mod N. Wrap at N, not at 2^W, so non-power-of-two N is legal.
  - Unused in MODE 0 and held at 0.
- Zero vector: the accept still occurs. Result: out_valid = 1, zero = 1, Y = 0, OD = 0, multi = 0. ptr is unchanged.
- multi = 1 iff popcount(I) ≥ 2 at accept. It is independent of MODE.
- OD = 1 << Y when zero = 0.

## Timing
- Reset values: out_valid 0, Y 0, OD 0, zero 0, multi 0, ptr 0. in_ready therefore reads 1 during and after reset.
- Reset asserted mid-operation: any held result is discarded immediately (asynchronously), with no output transfer. ptr returns to 0.
- Latency: a result accepted at edge k appears on the outputs with out_valid = 1 after edge k.
- Throughput: one result per cycle while out_ready stays 1.
- Simultaneous accept and release in the same cycle: the new result replaces the old one and out_valid stays 1. No bubble.
- out_ready = 0 with out_valid = 1: the outputs are held stable and in_ready = 0. I is ignored until the stall clears.
- I may change freely when in_valid = 0 or in_ready = 0; it is sampled only on accept.

## Test plan
- Reset and single-hot sweep, N=8, MODE 0, out_ready = 1:
  - Stimulus: after reset, drive I = 1<<i for i = 0..7, in_valid = 1.
  - Expected: the cycle after each accept shows Y = i, OD = I, multi = 0, zero = 0, out_valid = 1.
  - Check the reset values before the first accept.
- Fixed priority, multi-hot, N=8, MODE 0:
  - Stimulus: I = 8'b0101_0010.
  - Expected: Y = 6, OD = 8'b0100_0000, multi = 1.
  - Stimulus: I = 8'b0000_0000.
  - Expected: zero = 1, Y = 0, OD = 0, out_valid = 1.
- Round-robin fairness, N=8, MODE 1:
  - Stimulus: I = 8'b1000_0101 held for 4 accepts.
  - Expected: Y sequence 0, 2, 7, 0; ptr wraps 7→0 after the third grant.
  - Stimulus: a zero vector between grants.
  - Expected: ptr does not advance.
- Backpressure, N=8, MODE 0:
  - Stimulus: out_ready = 0 after the first result.
  - Expected: in_ready = 0 and Y/OD held for 3 cycles while I changes.
  - Stimulus: release out_ready = 1 with in_valid = 1.
  - Expected: new result appears the next cycle with no dropped or duplicated result.
  - Check throughput of 1 per cycle for 10 back-to-back inputs.
- Non-power-of-two, N=5, W=3, MODE 1:
  - Stimulus: I = 5'b10001 for 3 accepts.
  - Expected: Y = 0, 4, 0; ptr wraps to 0, never 5.
- Async reset mid-stall, N=8, MODE 1:
  - Stimulus: out_valid = 1, out_ready = 0, ptr = 3, then pulse rst between clock edges.
  - Expected: out_valid, Y, OD and ptr clear immediately, before the next edge.
  - Stimulus: first accept after reset with I = 8'b1111_1111.
  - Expected: Y = 0.
